// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: producer, consumer and RAM-port signals of the RAM-backed FIFO controller
interface ram_fifo_ctrl_if #(
  parameter int CAddrLen = 9,
  parameter int CDataLen = 32
);
  logic                AWrReq;
  logic [CDataLen-1:0] AWrData;
  logic                AWrFull;
  logic                ARdValid;
  logic [CDataLen-1:0] ARdData;
  logic                ARdAck;
  logic [CAddrLen:0]   ARamCount;
  logic [CAddrLen-1:0] ARamAddrWr;
  logic [CAddrLen-1:0] ARamAddrRd;
  logic [CDataLen-1:0] ARamMosi;
  logic                ARamWrEn;
  logic                ARamRdEn;
  logic [CDataLen-1:0] ARamMiso;
  modport slave (
    input  AWrReq, AWrData, ARdAck, ARamMiso,
    output AWrFull, ARdValid, ARdData, ARamCount, ARamAddrWr, ARamAddrRd, ARamMosi, ARamWrEn, ARamRdEn
  );
  modport master (
    output AWrReq, AWrData, ARdAck, ARamMiso,
    input  AWrFull, ARdValid, ARdData, ARamCount, ARamAddrWr, ARamAddrRd, ARamMosi, ARamWrEn, ARamRdEn
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO in an external one-cycle-latency RAM with a 2-entry registered output buffer
module ram_fifo_ctrl #(
  parameter int CAddrLen = 9,
  parameter int CDataLen = 32
) (
  input logic           AClkH,
  input logic           AResetH,
  ram_fifo_ctrl_if.slave bus
);
  localparam logic [CAddrLen:0] CDepth = {1'b1, {CAddrLen{1'b0}}};
  logic [CAddrLen-1:0] wrPtr, rdPtr;
  logic [CAddrLen:0]   ramCount;
  logic [1:0]          bufCount, remCount, occCount;
  logic [CDataLen-1:0] bufHead, bufTail;
  logic                inFlight, full, wr, rd, pop;
  // Reads are only issued when the buffer is guaranteed room for the returning word
  always_comb begin
    full     = ramCount == CDepth;
    pop      = bus.ARdAck & (bufCount != 2'd0);
    wr       = bus.AWrReq & ~full & ~AResetH;
    remCount = bufCount - {1'b0, pop};
    occCount = remCount + {1'b0, inFlight};
    rd       = ~wr & (ramCount != '0) & ~AResetH & (occCount < 2'd2);
    bus.AWrFull    = full;
    bus.ARdValid   = bufCount != 2'd0;
    bus.ARdData    = bufHead;
    bus.ARamCount  = ramCount;
    bus.ARamAddrWr = wrPtr;
    bus.ARamAddrRd = rdPtr;
    bus.ARamMosi   = bus.AWrData;
    bus.ARamWrEn   = wr;
    bus.ARamRdEn   = rd;
  end
  // Returning word lands behind whatever survives this cycle's pop
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      ramCount <= '0;
      inFlight <= 1'b0;
      bufCount <= 2'd0;
      bufHead  <= '0;
      bufTail  <= '0;
    end else begin
      wrPtr    <= wrPtr + CAddrLen'(wr);
      rdPtr    <= rdPtr + CAddrLen'(rd);
      ramCount <= ramCount + (CAddrLen+1)'(wr) - (CAddrLen+1)'(rd);
      inFlight <= rd;
      bufCount <= occCount;
      bufHead  <= (inFlight && remCount == 2'd0) ? bus.ARamMiso : pop ? bufTail : bufHead;
      bufTail  <= (inFlight && remCount == 2'd1) ? bus.ARamMiso : bufTail;
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed scenarios plus randomized traffic against a queue-based FIFO model
module tb_ram_fifo_ctrl;
  logic AClkH = 1'b0;
  logic AResetH = 1'b1;
  int   asserts = 0;
  int   failures = 0;
  logic [7:0] mem [4];
  ram_fifo_ctrl_if #(.CAddrLen(2), .CDataLen(8)) bus ();
  ram_fifo_ctrl #(.CAddrLen(2), .CDataLen(8)) dut (.AClkH(AClkH), .AResetH(AResetH), .bus(bus));
  always #5 AClkH = ~AClkH;
  always @(posedge AClkH) begin
    if (bus.ARamWrEn) mem[bus.ARamAddrWr] <= bus.ARamMosi;
    if (bus.ARamRdEn) bus.ARamMiso <= mem[bus.ARamAddrRd];
  end
  task automatic tick;
    @(posedge AClkH);
    #1;
  endtask
  task automatic setIn(input logic w, input logic [7:0] d, input logic a);
    bus.AWrReq = w;
    bus.AWrData = d;
    bus.ARdAck = a;
    #1;
  endtask
  task automatic doReset;
    AResetH = 1'b1;
    setIn(0, 8'h00, 0);
    tick;
    AResetH = 1'b0;
  endtask
  task automatic test_reset;
    AResetH = 1'b1;
    setIn(1, 8'h55, 1);
    asserts++; if (bus.ARamWrEn !== 1'b0) begin failures++; $display("FAIL reset_wren: got %b want 0", bus.ARamWrEn); end
    asserts++; if (bus.ARamRdEn !== 1'b0) begin failures++; $display("FAIL reset_rden: got %b want 0", bus.ARamRdEn); end
    tick;
    tick;
    AResetH = 1'b0;
    setIn(0, 8'h00, 0);
    asserts++; if (bus.ARdValid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.ARdValid); end
    asserts++; if (bus.AWrFull !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", bus.AWrFull); end
    asserts++; if (bus.ARamCount !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", bus.ARamCount); end
    asserts++; if (bus.ARdData !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", bus.ARdData); end
  endtask
  task automatic test_single_write;
    doReset;
    setIn(1, 8'hA5, 0);
    asserts++; if (bus.ARamWrEn !== 1'b1 || bus.ARamAddrWr !== 2'd0) begin failures++; $display("FAIL single_wr: got en=%b addr=%0d want en=1 addr=0", bus.ARamWrEn, bus.ARamAddrWr); end
    tick;
    setIn(0, 8'h00, 0);
    asserts++; if (bus.ARamRdEn !== 1'b1 || bus.ARamAddrRd !== 2'd0) begin failures++; $display("FAIL single_rd: got en=%b addr=%0d want en=1 addr=0", bus.ARamRdEn, bus.ARamAddrRd); end
    asserts++; if (bus.ARamCount !== 3'd1) begin failures++; $display("FAIL single_count1: got %0d want 1", bus.ARamCount); end
    tick;
    asserts++; if (bus.ARdValid !== 1'b0 || bus.ARamCount !== 3'd0) begin failures++; $display("FAIL single_e1: got valid=%b count=%0d want 0 0", bus.ARdValid, bus.ARamCount); end
    tick;
    asserts++; if (bus.ARdValid !== 1'b1 || bus.ARdData !== 8'hA5) begin failures++; $display("FAIL single_e2: got valid=%b data=%h want 1 a5", bus.ARdValid, bus.ARdData); end
    asserts++; if (bus.ARamCount !== 3'd0) begin failures++; $display("FAIL single_count2: got %0d want 0", bus.ARamCount); end
    setIn(0, 8'h00, 1);
    tick;
    setIn(0, 8'h00, 0);
    asserts++; if (bus.ARdValid !== 1'b0) begin failures++; $display("FAIL single_pop: got valid=%b want 0", bus.ARdValid); end
  endtask
  task automatic test_fill;
    int d = 1;
    int acc = 0;
    doReset;
    for (int c = 0; c < 12; c++) begin
      setIn(d <= 8, 8'(d), 0);
      asserts++; if (bus.ARamWrEn && bus.ARamRdEn) begin failures++; $display("FAIL fill_both_strobes: got 1 want 0 at cycle %0d", c); end
      if (bus.ARamWrEn) begin acc++; d++; end
      tick;
    end
    setIn(0, 8'h00, 0);
    asserts++; if (acc != 6) begin failures++; $display("FAIL fill_accepted: got %0d want 6", acc); end
    asserts++; if (bus.AWrFull !== 1'b1) begin failures++; $display("FAIL fill_full: got %b want 1", bus.AWrFull); end
    asserts++; if (bus.ARamCount !== 3'd4) begin failures++; $display("FAIL fill_count: got %0d want 4", bus.ARamCount); end
    asserts++; if (bus.ARdValid !== 1'b1 || bus.ARdData !== 8'd1) begin failures++; $display("FAIL fill_head: got valid=%b data=%0d want 1 1", bus.ARdValid, bus.ARdData); end
  endtask
  task automatic test_drain;
    setIn(0, 8'h00, 1);
    for (int i = 1; i <= 6; i++) begin
      asserts++; if (bus.ARdValid !== 1'b1 || bus.ARdData !== 8'(i)) begin failures++; $display("FAIL drain_%0d: got valid=%b data=%0d want 1 %0d", i, bus.ARdValid, bus.ARdData, i); end
      tick;
    end
    setIn(0, 8'h00, 0);
    asserts++; if (bus.ARdValid !== 1'b0 || bus.ARamCount !== 3'd0) begin failures++; $display("FAIL drain_end: got valid=%b count=%0d want 0 0", bus.ARdValid, bus.ARamCount); end
  endtask
  task automatic test_wrap;
    doReset;
    for (int i = 0; i < 10; i++) begin
      int n = 0;
      setIn(1, 8'(8'h10 + i), 0);
      asserts++; if (bus.ARamWrEn !== 1'b1 || bus.ARamAddrWr !== 2'(i % 4)) begin failures++; $display("FAIL wrap_addr_%0d: got en=%b addr=%0d want 1 %0d", i, bus.ARamWrEn, bus.ARamAddrWr, i % 4); end
      tick;
      setIn(0, 8'h00, 0);
      while (bus.ARdValid !== 1'b1 && n < 6) begin tick; n++; end
      asserts++; if (bus.ARdValid !== 1'b1 || bus.ARdData !== 8'(8'h10 + i)) begin failures++; $display("FAIL wrap_data_%0d: got valid=%b data=%h want 1 %h", i, bus.ARdValid, bus.ARdData, 8'h10 + i); end
      setIn(0, 8'h00, 1);
      tick;
      setIn(0, 8'h00, 0);
    end
  endtask
  task automatic test_reset_mid;
    int n = 0;
    doReset;
    for (int i = 0; i < 3; i++) begin setIn(1, 8'(8'hC0 + i), 0); tick; end
    setIn(0, 8'h00, 0);
    asserts++; if (bus.ARamRdEn !== 1'b1) begin failures++; $display("FAIL mid_rd: got %b want 1", bus.ARamRdEn); end
    tick;
    AResetH = 1'b1;
    setIn(1, 8'hEE, 0);
    asserts++; if (bus.ARamWrEn !== 1'b0 || bus.ARamRdEn !== 1'b0) begin failures++; $display("FAIL mid_strobes: got wr=%b rd=%b want 0 0", bus.ARamWrEn, bus.ARamRdEn); end
    tick;
    AResetH = 1'b0;
    setIn(0, 8'h00, 0);
    asserts++; if (bus.ARdValid !== 1'b0 || bus.ARamCount !== 3'd0) begin failures++; $display("FAIL mid_state: got valid=%b count=%0d want 0 0", bus.ARdValid, bus.ARamCount); end
    setIn(1, 8'h77, 0);
    asserts++; if (bus.ARamAddrWr !== 2'd0) begin failures++; $display("FAIL mid_addr: got %0d want 0", bus.ARamAddrWr); end
    tick;
    setIn(0, 8'h00, 0);
    while (bus.ARdValid !== 1'b1 && n < 6) begin tick; n++; end
    asserts++; if (bus.ARdValid !== 1'b1 || bus.ARdData !== 8'h77) begin failures++; $display("FAIL mid_data: got valid=%b data=%h want 1 77", bus.ARdValid, bus.ARdData); end
    setIn(0, 8'h00, 1);
    tick;
    setIn(0, 8'h00, 0);
  endtask
  task automatic test_collision;
    doReset;
    setIn(1, 8'h31, 0); tick;
    setIn(1, 8'h32, 0); tick;
    setIn(0, 8'h00, 0); tick;
    tick;
    asserts++; if (bus.ARdValid !== 1'b1 || bus.ARdData !== 8'h31) begin failures++; $display("FAIL coll_head: got valid=%b data=%h want 1 31", bus.ARdValid, bus.ARdData); end
    setIn(0, 8'h00, 1);
    tick;
    setIn(0, 8'h00, 0);
    asserts++; if (bus.ARdValid !== 1'b1 || bus.ARdData !== 8'h32) begin failures++; $display("FAIL coll_next: got valid=%b data=%h want 1 32", bus.ARdValid, bus.ARdData); end
    setIn(0, 8'h00, 1);
    tick;
    setIn(0, 8'h00, 0);
    asserts++; if (bus.ARdValid !== 1'b0) begin failures++; $display("FAIL coll_empty: got %b want 0", bus.ARdValid); end
  endtask
  task automatic test_random;
    logic [7:0] q[$];
    int mRam = 0, mInFl = 0, wPtr = 0, rPtr = 0;
    doReset;
    for (int c = 0; c < 500; c++) begin
      int wPct = c < 150 ? 80 : c < 300 ? 45 : c < 420 ? 20 : 0;
      int aPct = c < 150 ? 25 : c < 300 ? 70 : 90;
      logic wreq = $urandom_range(0, 99) < wPct;
      logic ack = $urandom_range(0, 99) < aPct;
      logic [7:0] d = 8'($urandom);
      int bufc = q.size() - mRam - mInFl;
      bit full = mRam == 4;
      bit wr = wreq && !full;
      bit pop = ack && bufc != 0;
      bit rd = !wr && mRam != 0 && (bufc + mInFl - int'(pop) < 2);
      setIn(wreq, d, ack);
      asserts++; if (bus.AWrFull !== full) begin failures++; $display("FAIL rnd_full c%0d: got %b want %b", c, bus.AWrFull, full); end
      asserts++; if (bus.ARamCount !== 3'(mRam)) begin failures++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bus.ARamCount, mRam); end
      asserts++; if (bus.ARdValid !== (bufc != 0)) begin failures++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.ARdValid, bufc != 0); end
      if (bufc != 0) begin
        asserts++; if (bus.ARdData !== q[0]) begin failures++; $display("FAIL rnd_data c%0d: got %h want %h", c, bus.ARdData, q[0]); end
      end
      asserts++; if (bus.ARamWrEn !== wr) begin failures++; $display("FAIL rnd_wren c%0d: got %b want %b", c, bus.ARamWrEn, wr); end
      asserts++; if (bus.ARamRdEn !== rd) begin failures++; $display("FAIL rnd_rden c%0d: got %b want %b", c, bus.ARamRdEn, rd); end
      if (wr) begin
        asserts++; if (bus.ARamAddrWr !== 2'(wPtr % 4) || bus.ARamMosi !== d) begin failures++; $display("FAIL rnd_wraddr c%0d: got %0d/%h want %0d/%h", c, bus.ARamAddrWr, bus.ARamMosi, wPtr % 4, d); end
      end
      if (rd) begin
        asserts++; if (bus.ARamAddrRd !== 2'(rPtr % 4)) begin failures++; $display("FAIL rnd_rdaddr c%0d: got %0d want %0d", c, bus.ARamAddrRd, rPtr % 4); end
      end
      if (pop) void'(q.pop_front());
      if (wr) q.push_back(d);
      mRam += int'(wr) - int'(rd);
      mInFl = int'(rd);
      wPtr += int'(wr);
      rPtr += int'(rd);
      tick;
    end
    setIn(0, 8'h00, 0);
    asserts++; if (q.size() != 0 || bus.ARdValid !== 1'b0) begin failures++; $display("FAIL rnd_drained: got left=%0d valid=%b want 0 0", q.size(), bus.ARdValid); end
  endtask
  initial begin
    setIn(0, 8'h00, 0);
    test_reset;
    test_single_write;
    test_fill;
    test_drain;
    test_wrap;
    test_reset_mid;
    test_collision;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter CAddrLen, default 9, RAM address width; FIFO RAM depth is 2**CAddrLen entries.
REQ-002 SHALL have parameter CDataLen, default 32, data word width.
REQ-003 SHALL have port AClkH  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port AResetH  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port AWrReq  input  1  producer write request.
REQ-006 SHALL have port AWrData  input  CDataLen  producer write data.
REQ-007 SHALL have port AWrFull  output  1  RAM holds 2**CAddrLen entries; a write is refused.
REQ-008 SHALL have port ARdValid  output  1  ARdData holds the FIFO head.
REQ-009 SHALL have port ARdData  output  CDataLen  FIFO head word.
REQ-010 SHALL have port ARdAck  input  1  consumer pops the head.
REQ-011 SHALL have port ARamCount  output  CAddrLen+1  entries resident in the RAM, excluding output buffer and in-flight read.
REQ-012 SHALL have ports ARamAddrWr and ARamAddrRd  output  CAddrLen each  RAM write and read addresses.
REQ-013 SHALL have port ARamMosi  output  CDataLen  RAM write data.
REQ-014 SHALL have port ARamWrEn  output  1  RAM write strobe.
REQ-015 SHALL have port ARamRdEn  output  1  RAM read strobe.
REQ-016 SHALL have port ARamMiso  input  CDataLen  RAM read data; valid one edge after a read strobe; equals write data in a write cycle.

Function
REQ-017 SHALL accept a write (Wr) when AWrReq=1, AWrFull=0 and AResetH=0.
- ARamWrEn=Wr, combinational.
- ARamMosi=AWrData; ARamAddrWr=write pointer.
- Write pointer increments modulo 2**CAddrLen on each Wr.
REQ-018 SHALL issue a RAM read (Rd) only when all hold: Wr=0, ARamCount!=0, AResetH=0, and BufCount+InFlight-Pop<2.
- Pop=ARdAck&ARdValid.
- Writes have strict priority; Rd and ARamWrEn are never both 1.
REQ-019 SHALL drive ARamRdEn=Rd and ARamAddrRd=read pointer; the read pointer increments modulo 2**CAddrLen on each Rd.
REQ-020 SHALL set InFlight=1 on the edge ending a Rd cycle.
- At the next edge, ARamMiso is captured into the 2-entry in-order output buffer and InFlight clears.
- A new Rd in that cycle keeps InFlight=1.
REQ-021 SHALL update ARamCount +1 on Wr and -1 on Rd; AWrFull=(ARamCount==2**CAddrLen), registered-count based.
REQ-022 SHALL hold ARdValid=(BufCount!=0) and ARdData=oldest buffer entry, both registered.
- ARdData stays stable while ARdValid=1 and ARdAck=0.
REQ-023 SHALL ignore ARdAck when ARdValid=0.
- Capture and Pop in the same edge: new word appends behind the remaining entry; order is preserved.
REQ-024 SHALL give a latency from the edge accepting a write into an empty FIFO to ARdValid=1 of 2 edges, when no write occurs in the following cycle.
REQ-025 SHALL sustain one pop per cycle when ARdAck=1, no writes occur and ARamCount>0.
REQ-026 SHALL preserve strict FIFO order across pointer wrap-around.

Reset
REQ-027 SHALL, on an edge with AResetH=1, clear both pointers, ARamCount, BufCount and InFlight.
- Outputs after reset: ARdValid=0, AWrFull=0, ARamCount=0, ARdData=0.
REQ-028 SHALL force ARamWrEn=0 and ARamRdEn=0 while AResetH=1.
- RAM data returning from a read issued before reset is discarded.
REQ-029 SHALL require no initialisation of RAM contents.

Verification
Bench parameters: CAddrLen=2, CDataLen=8.
REQ-030 SHALL cover single write: reset, write 0xA5 at edge E0, AWrReq=0 after -> Rd in cycle after E0; ARdValid=1, ARdData=0xA5, ARamCount=0 after E2.
REQ-031 SHALL cover fill: AWrReq held 1, ARdAck=0, data 1..8 -> exactly 6 writes accepted; final AWrFull=1, ARamCount=4, ARdData=1, never ARamWrEn&ARamRdEn.
REQ-032 SHALL cover drain: from REQ-031 end state, AWrReq=0, ARdAck=1 -> data 1..6 popped one per cycle in order; ARdValid=0 and ARamCount=0 at end.
REQ-033 SHALL cover wrap: 10 single writes, each popped before the next, values 0x10..0x19 -> outputs 0x10..0x19 in order; ARamAddrWr sequence 0,1,2,3,0,1,...
REQ-034 SHALL cover reset mid-operation: 3 entries, InFlight=1, AResetH high for one edge -> ARdValid=0, ARamCount=0; next write goes to ARamAddrWr=0 and is the next word output.
REQ-035 SHALL cover pop/capture collision: BufCount=1, capture and ARdAck in the same edge -> ARdData advances to the captured word and ARdValid stays 1.
